sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 120 ++++++++++++
 tb/tb_sync_fifo_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Synchronous FIFO for any DEPTH 2..256, with a registered read port and status flags.
// Define FIFO_ERR_FLAGS_EN to get the sticky overflow/underflow flags.
// Revision : 1.0
// ============================================================================
module sync_fifo_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 10,
  parameter int AF_LEVEL = 8,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       wn,
  input  logic                       rn,
  input  logic [WIDTH-1:0]           DATAIN,
  output logic [WIDTH-1:0]           DATAOUT,
  output logic                       dvalid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int            CW         = $clog2(DEPTH + 1);
  localparam int            PW         = $clog2(DEPTH);
  localparam logic [PW-1:0] C_PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q;
  logic             w_wa;
  logic             w_ra;

  // A write at full is accepted only when a read frees a slot in the same cycle.
  assign w_wa = wn && (!full || rn);
  assign w_ra = rn && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (w_wa) begin
      wptr_d = (wptr_q == C_PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (w_ra) begin
      rptr_d = (rptr_q == C_PTR_LAST) ? '0 : rptr_q + 1'b1;
      dout_d = mem_q[rptr_q];
    end
    case ({w_wa, w_ra})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= w_ra;
    end
  end

  // Storage is not reset; when full, the freed slot is read before being overwritten.
  always_ff @(posedge clock) begin
    if (rst_n && w_wa) begin
      mem_q[wptr_q] <= DATAIN;
    end
  end

  assign DATAOUT      = dout_q;
  assign dvalid       = dvalid_q;
  assign count        = count_q;
  assign full         = (count_q == C_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wn && full && !rn) overflow_q  <= 1'b1;
      if (rn && empty)       underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Self-checking bench for sync_fifo_param: vector table, directed corners, random vs queue model.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_param;

  localparam int A_DEPTH = 10;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        r_rst_n, r_wn, r_rn;
  logic [15:0] r_din;
  logic [15:0] w_dout;
  logic [3:0]  w_count;
  logic        w_dv, w_full, w_empty, w_af, w_ae, w_ovf, w_unf;

  logic        r_b_rst_n, r_b_wn, r_b_rn;
  logic [7:0]  r_b_din;
  logic [7:0]  w_b_dout;
  logic [2:0]  w_b_count;
  logic        w_b_dv, w_b_full, w_b_empty, w_b_af, w_b_ae, w_b_ovf, w_b_unf;

  int n_err;
  int n_checks;

  logic [15:0] mq[$];
  logic [15:0] m_dout;
  logic        m_dv, m_ovf, m_unf;

  sync_fifo_param u_dut_a (
    .clock(clk), .rst_n(r_rst_n), .wn(r_wn), .rn(r_rn), .DATAIN(r_din),
    .DATAOUT(w_dout), .dvalid(w_dv), .full(w_full), .empty(w_empty),
    .almost_full(w_af), .almost_empty(w_ae), .count(w_count),
    .overflow(w_ovf), .underflow(w_unf)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut_b (
    .clock(clk), .rst_n(r_b_rst_n), .wn(r_b_wn), .rn(r_b_rn), .DATAIN(r_b_din),
    .DATAOUT(w_b_dout), .dvalid(w_b_dv), .full(w_b_full), .empty(w_b_empty),
    .almost_full(w_b_af), .almost_empty(w_b_ae), .count(w_b_count),
    .overflow(w_b_ovf), .underflow(w_b_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wn;
    logic        rn;
    logic [15:0] din;
    int          exp_count;
    logic [15:0] exp_dout;
    logic        exp_dv;
    logic        exp_full;
    logic        exp_af;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_a();
    int sz;
    sz = mq.size();
    chk("a_count",  64'(w_count), 64'(sz));
    chk("a_dout",   64'(w_dout),  64'(m_dout));
    chk("a_dvalid", 64'(w_dv),    64'(m_dv));
    chk("a_full",   64'(w_full),  64'(sz == A_DEPTH));
    chk("a_empty",  64'(w_empty), 64'(sz == 0));
    chk("a_afull",  64'(w_af),    64'(sz >= 8));
    chk("a_aempty", 64'(w_ae),    64'(sz <= 2));
    chk("a_ovf",    64'(w_ovf),   64'(ERR_EN && m_ovf));
    chk("a_unf",    64'(w_unf),   64'(ERR_EN && m_unf));
  endtask

  // Drive one cycle into instance A, advance the queue model, then compare.
  task automatic step_a(input logic wn, input logic rn, input logic rstn, input logic [15:0] din);
    int sz;
    bit wa, ra;
    r_wn = wn; r_rn = rn; r_rst_n = rstn; r_din = din;
    @(posedge clk);
    if (!rstn) begin
      mq.delete();
      m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      sz = mq.size();
      wa = wn && (sz < A_DEPTH || rn);
      ra = rn && (sz > 0);
      if (wn && sz == A_DEPTH && !rn) m_ovf = 1'b1;
      if (rn && sz == 0)             m_unf = 1'b1;
      m_dv = ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(din);
    end
    #1;
    compare_a();
  endtask

  task automatic step_b(input logic wn, input logic rn, input logic rstn, input logic [7:0] din);
    r_b_wn = wn; r_b_rn = rn; r_b_rst_n = rstn; r_b_din = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wbias;
    logic [15:0] exp_rd;
    n_err = 0; n_checks = 0;
    r_rst_n = 1'b0; r_wn = 1'b0; r_rn = 1'b0; r_din = '0;
    r_b_rst_n = 1'b0; r_b_wn = 1'b0; r_b_rn = 1'b0; r_b_din = '0;
    m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    // Fill 10, overflow attempt, drain 10, then read at empty.
    for (int i = 0; i < 10; i++)
      tbl[i] = '{1'b1, 1'b0, 16'(i + 1), i + 1, 16'h0000, 1'b0, (i == 9), (i + 1 >= 8)};
    tbl[10] = '{1'b1, 1'b0, 16'h00FF, 10, 16'h0000, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 10; k++)
      tbl[11 + k] = '{1'b0, 1'b1, 16'h0000, 9 - k, 16'(k + 1), 1'b1, 1'b0, (9 - k >= 8)};
    tbl[21] = '{1'b0, 1'b1, 16'h0000, 0, 16'h000A, 1'b0, 1'b0, 1'b0};

    step_a(1'b1, 1'b1, 1'b0, 16'hFFFF);
    step_a(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 22; i++) begin
      step_a(tbl[i].wn, tbl[i].rn, 1'b1, tbl[i].din);
      chk($sformatf("tbl%0d_count", i), 64'(w_count), 64'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_dout", i),  64'(w_dout),  64'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_dv", i),    64'(w_dv),    64'(tbl[i].exp_dv));
      chk($sformatf("tbl%0d_full", i),  64'(w_full),  64'(tbl[i].exp_full));
      chk($sformatf("tbl%0d_af", i),    64'(w_af),    64'(tbl[i].exp_af));
    end

    // Steady state at full: simultaneous read/write, pointers wrap.
    step_a(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) step_a(1'b1, 1'b0, 1'b1, 16'(16'h0100 + i));
    for (int i = 0; i < 15; i++) begin
      step_a(1'b1, 1'b1, 1'b1, 16'(16'h0200 + i));
      exp_rd = (i < 10) ? 16'(16'h0100 + i) : 16'(16'h0200 + i - 10);
      chk("wrap_count", 64'(w_count), 64'd10);
      chk("wrap_dout",  64'(w_dout),  64'(exp_rd));
      chk("wrap_dv",    64'(w_dv),    64'd1);
    end
    for (int i = 0; i < 11; i++) step_a(1'b0, 1'b1, 1'b1, 16'h0000);

    // Empty with write and read together: no bypass.
    step_a(1'b0, 1'b0, 1'b0, 16'h0000);
    step_a(1'b1, 1'b1, 1'b1, 16'h1234);
    chk("nobypass_count", 64'(w_count), 64'd1);
    chk("nobypass_dv",    64'(w_dv),    64'd0);
    step_a(1'b0, 1'b1, 1'b1, 16'h0000);
    chk("nobypass_dout",  64'(w_dout),  64'h1234);
    chk("nobypass_dv2",   64'(w_dv),    64'd1);

    // Underflow stickiness and reset clearing.
    step_a(1'b1, 1'b0, 1'b1, 16'h55AA);
    step_a(1'b0, 1'b1, 1'b1, 16'h0000);
    step_a(1'b0, 1'b1, 1'b1, 16'h0000);
    step_a(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("unf_held",  64'(w_unf),  64'(ERR_EN));
    chk("unf_dout",  64'(w_dout), 64'h55AA);
    step_a(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("rst_unf",   64'(w_unf),   64'd0);
    chk("rst_count", 64'(w_count), 64'd0);
    chk("rst_dout",  64'(w_dout),  64'd0);

    // Randomized traffic with varying write bias and occasional resets.
    wbias = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) wbias = (c / 100) % 3 == 0 ? 80 : ((c / 100) % 3 == 1 ? 20 : 50);
      step_a(($urandom_range(0, 99) < wbias), ($urandom_range(0, 99) < 50),
             ($urandom_range(0, 199) != 0), 16'($urandom));
    end

    // Small power-of-2 configuration with custom thresholds.
    step_b(1'b0, 1'b0, 1'b0, 8'h00);
    chk("b_rst_empty", 64'(w_b_empty), 64'd1);
    chk("b_rst_ae",    64'(w_b_ae),    64'd1);
    chk("b_rst_af",    64'(w_b_af),    64'd0);
    step_b(1'b1, 1'b0, 1'b1, 8'h11);
    step_b(1'b1, 1'b0, 1'b1, 8'h22);
    chk("b_af_at2",    64'(w_b_af),    64'd0);
    chk("b_ae_at2",    64'(w_b_ae),    64'd0);
    step_b(1'b1, 1'b0, 1'b1, 8'h33);
    chk("b_count3",    64'(w_b_count), 64'd3);
    chk("b_af_at3",    64'(w_b_af),    64'd1);
    chk("b_full_at3",  64'(w_b_full),  64'd0);
    step_b(1'b0, 1'b1, 1'b1, 8'h00);
    chk("b_rd1",       64'(w_b_dout),  64'h11);
    chk("b_ae_at2b",   64'(w_b_ae),    64'd0);
    step_b(1'b0, 1'b1, 1'b1, 8'h00);
    chk("b_rd2",       64'(w_b_dout),  64'h22);
    chk("b_count1",    64'(w_b_count), 64'd1);
    chk("b_ae_at1",    64'(w_b_ae),    64'd1);
    for (int i = 0; i < 3; i++) step_b(1'b1, 1'b0, 1'b1, 8'(8'h40 + i));
    chk("b_full",      64'(w_b_full),  64'd1);
    chk("b_count4",    64'(w_b_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      step_b(1'b0, 1'b1, 1'b1, 8'h00);
      chk("b_drain", 64'(w_b_dout), (i == 0) ? 64'h33 : 64'(8'h40 + i - 1));
    end
    chk("b_empty_end", 64'(w_b_empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
